// File: rtl/reg_bank_pkg.sv
// Shared types, sizing helpers and the byte-lane merge for the byte-enable register bank.
package reg_bank_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_READ_LAT   = 2;
    localparam int NUM_BYTES      = DEF_DATA_WIDTH / 8;
    localparam int LAT_CTR_W      = $clog2(DEF_READ_LAT + 1);

    // Widest word byte_merge handles; callers zero-extend narrower words.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    function automatic int num_bytes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int lat_ctr_w(input int read_lat);
        return $clog2(read_lat + 1);
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BYTES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg_bank_lat_ctr.sv
// Loadable down-counter that times the read latency; done is high while the count is zero.
module reg_bank_lat_ctr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/reg_bank_be.sv
// Control/status register bank with byte-enable writes, write protect and fixed-latency reads.
//   state   | meaning
//   IDLE    | ready=1; writes complete at the accepting edge, reads are captured
//   RD_WAIT | ready=0; latency counter running, rvalid issued when it reaches zero
module reg_bank_be
    import reg_bank_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 16'h1507,
    parameter int                    READ_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    wp,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    ready,
    output logic                    err
);

    localparam int                  NB      = num_bytes(DATA_WIDTH);
    localparam int                  LAT_W   = lat_ctr_w(READ_LAT);
    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   hold_data;
    logic                    hold_err;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   cur_word;
    logic [DATA_WIDTH-1:0]   merged;
    logic [MAX_DATA_W-1:0]   old_ext;
    logic [MAX_DATA_W-1:0]   new_ext;
    logic [MAX_BYTES-1:0]    be_ext;
    logic [MAX_DATA_W-1:0]   merged_ext;
    logic                    acc_wr;
    logic                    acc_rd;
    logic                    wr_ok;
    logic                    ctr_done;

    assign ready    = (state == IDLE);
    assign acc_wr   = ready & sel & wr;
    assign acc_rd   = ready & sel & ~wr;
    assign in_range = ({1'b0, addr} < DEPTH_C);
    assign wr_ok    = acc_wr & in_range & ~wp;

    // Out-of-range addresses never reach the array index, so no aliasing onto low registers.
    assign idx      = in_range ? addr[IDX_W-1:0] : '0;
    assign cur_word = in_range ? mem[idx] : '0;

    always_comb begin
        old_ext                   = '0;
        new_ext                   = '0;
        be_ext                    = '0;
        old_ext[DATA_WIDTH-1:0]   = cur_word;
        new_ext[DATA_WIDTH-1:0]   = wdata;
        be_ext[NB-1:0]            = be;
        merged_ext                = byte_merge(old_ext, new_ext, be_ext);
        merged                    = merged_ext[DATA_WIDTH-1:0];
    end

    generate
        if (DATA_WIDTH < MAX_DATA_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^merged_ext[MAX_DATA_W-1:DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else if (wr_ok) begin
            mem[idx] <= merged;
        end
    end

    reg_bank_lat_ctr #(
        .WIDTH (LAT_W)
    ) u_lat_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (acc_rd),
        .en       (state == RD_WAIT),
        .load_val (LAT_W'(READ_LAT - 1)),
        .done     (ctr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rvalid    <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            hold_data <= '0;
            hold_err  <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc_wr && (!in_range || wp)) begin
                        err <= 1'b1;
                    end else if (acc_rd) begin
                        hold_data <= cur_word;
                        hold_err  <= ~in_range;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (ctr_done) begin
                        rvalid <= 1'b1;
                        rdata  <= hold_data;
                        err    <= hold_err;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_be.sv
// Directed bench for reg_bank_be with DEPTH=200 and READ_LAT=3.
module tb_reg_bank_be;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 200;
    localparam int LAT   = 3;
    localparam logic [DW-1:0] RV = 16'h1507;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    logic          wr = 1'b0;
    logic          wp = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [1:0]    be = '0;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          ready;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_bank_be #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_VAL  (RV),
        .READ_LAT   (LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .be     (be),
        .wp     (wp),
        .rdata  (rdata),
        .rvalid (rvalid),
        .ready  (ready),
        .err    (err)
    );

    // Called at posedge+1; returns one sample after the accepting edge.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        sel = 1'b0; wr = 1'b0;
    endtask

    // Returns at the sample where rvalid was seen (lat = cycles after acceptance, -1 on timeout).
    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic e,
                           output int lat, output logic rdy_ok);
        sel = 1'b1; wr = 1'b0; addr = a; be = 2'b11;
        @(posedge clk); #1;
        sel = 1'b0;
        lat = -1; rdy_ok = 1'b1; d = '0; e = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            if (rvalid === 1'b1) begin
                lat = k; d = rdata; e = err;
                if (ready !== 1'b1) rdy_ok = 1'b0;
                break;
            end
            if (ready !== 1'b0 || err !== 1'b0 || rdata !== '0) rdy_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d; logic e; int lat; logic ok;
        rst = 1'b1;
        #12;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got %h exp 0000", rdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b exp 1", ready); end
        do_read(8'h00, d, e, lat, ok);
        n_checks++; if (d !== RV) begin n_fail++; $display("FAIL reset_rd00_data got %h exp %h", d, RV); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL reset_rd00_err got %b exp 0", e); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL reset_rd00_lat got %0d exp %0d", lat, LAT); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reset_rd00_handshake got %b exp 1", ok); end
        do_read(8'hC7, d, e, lat, ok);
        n_checks++; if (d !== RV) begin n_fail++; $display("FAIL reset_rdC7_data got %h exp %h", d, RV); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL reset_rdC7_lat got %0d exp %0d", lat, LAT); end
    endtask

    task automatic test_byte_enable();
        logic [DW-1:0] d; logic e; int lat; logic ok;
        do_write(8'h12, 16'hABCD, 2'b11);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL be_wr11_err got %b exp 0", err); end
        do_write(8'h12, 16'h0099, 2'b01);
        do_read(8'h12, d, e, lat, ok);
        n_checks++; if (d !== 16'hAB99) begin n_fail++; $display("FAIL be_lo_data got %h exp ab99", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL be_lo_err got %b exp 0", e); end
        do_write(8'h12, 16'h7766, 2'b10);
        do_write(8'h12, 16'hFFFF, 2'b00);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL be_none_err got %b exp 0", err); end
        do_read(8'h12, d, e, lat, ok);
        n_checks++; if (d !== 16'h7799) begin n_fail++; $display("FAIL be_hi_data got %h exp 7799", d); end
    endtask

    task automatic test_latency();
        int lat; logic early; logic [DW-1:0] got; logic got_err; logic got_rdy;
        sel = 1'b1; wr = 1'b0; addr = 8'h12;
        @(posedge clk); #1;
        // master holds an out-of-range write while the read is outstanding
        wr = 1'b1; addr = 8'hC8; wdata = 16'hFFFF; be = 2'b11;
        lat = -1; early = 1'b0; got = '0; got_err = 1'b0; got_rdy = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            if (rvalid === 1'b1) begin
                lat = k; got = rdata; got_err = err; got_rdy = ready;
                break;
            end
            if (ready !== 1'b0 || err !== 1'b0) early = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL lat_cycles got %0d exp %0d", lat, LAT); end
        n_checks++; if (got !== 16'h7799) begin n_fail++; $display("FAIL lat_data got %h exp 7799", got); end
        n_checks++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL lat_err got %b exp 0", got_err); end
        n_checks++; if (got_rdy !== 1'b1) begin n_fail++; $display("FAIL lat_ready_at_rvalid got %b exp 1", got_rdy); end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL lat_wait_quiet got %b exp 0", early); end
        @(posedge clk); #1;
        sel = 1'b0; wr = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL lat_held_wr_err got %b exp 1", err); end
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL lat_rvalid_drop got %b exp 0", rvalid); end
        n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL lat_rdata_drop got %h exp 0000", rdata); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d; logic e; int lat; logic ok;
        sel = 1'b1; wr = 1'b1; be = 2'b11;
        for (int i = 0; i < 3; i++) begin
            addr = AW'(8'h20 + i); wdata = DW'(16'h1020 + i);
            @(posedge clk); #1;
            n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got %b exp 1", i, ready); end
        end
        sel = 1'b0; wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_read(AW'(8'h20 + i), d, e, lat, ok);
            n_checks++; if (d !== DW'(16'h1020 + i)) begin n_fail++; $display("FAIL b2b_rd_%0d got %h exp %h", i, d, DW'(16'h1020 + i)); end
            n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_lat_%0d got %0d exp %0d", i, lat, LAT); end
        end
        // valid write held across an outstanding read must land once ready returns
        sel = 1'b1; wr = 1'b0; addr = 8'h20;
        @(posedge clk); #1;
        wr = 1'b1; addr = 8'h23; wdata = 16'h2323; be = 2'b11;
        for (int k = 0; k <= 20; k++) begin
            if (ready === 1'b1) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        sel = 1'b0; wr = 1'b0;
        do_read(8'h23, d, e, lat, ok);
        n_checks++; if (d !== 16'h2323) begin n_fail++; $display("FAIL b2b_held_wr got %h exp 2323", d); end
    endtask

    task automatic test_errors();
        logic [DW-1:0] d; logic e; int lat; logic ok;
        do_write(8'hC8, 16'hFFFF, 2'b11);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_wrC8 got %b exp 1", err); end
        @(posedge clk); #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got %b exp 0", err); end
        do_write(8'hFF, 16'hFFFF, 2'b11);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_wrFF got %b exp 1", err); end
        do_write(8'hC7, 16'hFFFF, 2'b00);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_be0_inrange got %b exp 0", err); end
        do_read(8'hC8, d, e, lat, ok);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL err_rdC8_data got %h exp 0000", d); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_rdC8_err got %b exp 1", e); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL err_rdC8_lat got %0d exp %0d", lat, LAT); end
        @(posedge clk); #1;
        n_checks++; if (err !== 1'b0 || rvalid !== 1'b0) begin n_fail++; $display("FAIL err_rd_clear got err=%b rvalid=%b exp 0 0", err, rvalid); end
        do_read(8'hC7, d, e, lat, ok);
        n_checks++; if (d !== RV) begin n_fail++; $display("FAIL err_rdC7_untouched got %h exp %h", d, RV); end
        do_read(8'h00, d, e, lat, ok);
        n_checks++; if (d !== RV) begin n_fail++; $display("FAIL err_rd00_untouched got %h exp %h", d, RV); end
    endtask

    task automatic test_write_protect();
        logic [DW-1:0] d; logic e; int lat; logic ok;
        wp = 1'b1;
        do_write(8'h05, 16'h5555, 2'b11);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL wp_wr_err got %b exp 1", err); end
        do_read(8'h05, d, e, lat, ok);
        n_checks++; if (d !== RV) begin n_fail++; $display("FAIL wp_rd_data got %h exp %h", d, RV); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL wp_rd_err got %b exp 0", e); end
        wp = 1'b0;
        do_write(8'h05, 16'h5555, 2'b11);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wp_off_err got %b exp 0", err); end
        do_read(8'h05, d, e, lat, ok);
        n_checks++; if (d !== 16'h5555) begin n_fail++; $display("FAIL wp_off_data got %h exp 5555", d); end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] d; logic e; int lat; logic ok; logic seen;
        sel = 1'b1; wr = 1'b0; addr = 8'h05;
        @(posedge clk); #1;
        sel = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rmr_in_wait got ready=%b exp 0", ready); end
        rst = 1'b1;
        #2;
        n_checks++; if (ready !== 1'b1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_async got ready=%b rvalid=%b exp 1 0", ready, rvalid); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rvalid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmr_no_rvalid got %b exp 0", seen); end
        do_read(8'h05, d, e, lat, ok);
        n_checks++; if (d !== RV) begin n_fail++; $display("FAIL rmr_rd05 got %h exp %h", d, RV); end
        do_read(8'h12, d, e, lat, ok);
        n_checks++; if (d !== RV) begin n_fail++; $display("FAIL rmr_rd12 got %h exp %h", d, RV); end
        do_read(8'h23, d, e, lat, ok);
        n_checks++; if (d !== RV) begin n_fail++; $display("FAIL rmr_rd23 got %h exp %h", d, RV); end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_latency();
        test_back_to_back();
        test_errors();
        test_write_protect();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
